// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes, ALUOp encodings and R-type funct values,
// used by both the ID/EX stage decoder and the ALU.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0110,
        ALU_SLT     = 4'b0111,
        ALU_NOR     = 4'b1100,
        ALU_ILLEGAL = 4'b1111
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// Combinational ALUOp/funct decode into a 4-bit ALU control code plus an illegal-op flag.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    FUNCT_NOR: alu_control = ALU_NOR;
                    default: begin
                        alu_control = ALU_ILLEGAL;
                        illegal     = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX single-entry pipeline register with valid/ready handshake, flush and ALU decode.
// Optional operand forwarding from EX/MEM and MEM/WB is enabled by defining FORWARD_EN.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] Read_data1,
    input  logic [31:0] Read_data2,
    input  logic [31:0] Sign_ext_imm,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic [5:0]  funct,
    input  logic [1:0]  ALUOp,
    input  logic        ALUSrc,
    input  logic        RegDst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        flush,
    input  logic        out_ready,
`ifdef FORWARD_EN
    input  logic        Exmem_RegWrite,
    input  logic [4:0]  Exmem_rd,
    input  logic [31:0] Exmem_data,
    input  logic        Memwb_RegWrite,
    input  logic [4:0]  Memwb_rd,
    input  logic [31:0] Memwb_data,
`endif
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [3:0]  ALU_Control,
    output logic [31:0] Store_data,
    output logic [4:0]  Write_reg,
    output logic        MemRead_q,
    output logic        MemWrite_q,
    output logic        MemtoReg_q,
    output logic        RegWrite_q,
    output logic        Illegal_op
);

    logic [31:0] rs_operand;
    logic [31:0] rt_operand;
    logic [4:0]  write_reg_sel;
    logic [3:0]  dec_control;
    logic        dec_illegal;
    logic        capture;

`ifdef FORWARD_EN
    // EX/MEM is the younger result, so it is checked first and wins over MEM/WB.
    always_comb begin
        rs_operand = Read_data1;
        if (Exmem_RegWrite && Exmem_rd != 5'd0 && Exmem_rd == Rs)
            rs_operand = Exmem_data;
        else if (Memwb_RegWrite && Memwb_rd != 5'd0 && Memwb_rd == Rs)
            rs_operand = Memwb_data;
    end

    always_comb begin
        rt_operand = Read_data2;
        if (Exmem_RegWrite && Exmem_rd != 5'd0 && Exmem_rd == Rt)
            rt_operand = Exmem_data;
        else if (Memwb_RegWrite && Memwb_rd != 5'd0 && Memwb_rd == Rt)
            rt_operand = Memwb_data;
    end
`else
    assign rs_operand = Read_data1;
    assign rt_operand = Read_data2;
`endif

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op      (ALUOp),
        .funct       (funct),
        .alu_control (dec_control),
        .illegal     (dec_illegal)
    );

    assign in_ready      = !out_valid || out_ready;
    assign capture       = in_valid && in_ready && !flush;
    assign write_reg_sel = RegDst ? Rd : Rt;

    // Reset beats flush, flush beats capture; a stalled entry simply holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            ALU_A       <= 32'd0;
            ALU_B       <= 32'd0;
            ALU_Control <= ALU_ADD;
            Store_data  <= 32'd0;
            Write_reg   <= 5'd0;
            MemRead_q   <= 1'b0;
            MemWrite_q  <= 1'b0;
            MemtoReg_q  <= 1'b0;
            RegWrite_q  <= 1'b0;
            Illegal_op  <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            MemRead_q  <= 1'b0;
            MemWrite_q <= 1'b0;
            RegWrite_q <= 1'b0;
            Illegal_op <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            ALU_A       <= rs_operand;
            ALU_B       <= ALUSrc ? Sign_ext_imm : rt_operand;
            ALU_Control <= dec_control;
            Store_data  <= rt_operand;
            Write_reg   <= write_reg_sel;
            MemRead_q   <= MemRead && !dec_illegal;
            MemWrite_q  <= MemWrite && !dec_illegal;
            MemtoReg_q  <= MemtoReg;
            RegWrite_q  <= RegWrite && !dec_illegal && (write_reg_sel != 5'd0);
            Illegal_op  <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 Decode-side inputs SHALL be: in_valid 1; Read_data1 32; Read_data2 32; Sign_ext_imm 32; Rs 5; Rt 5; Rd 5; funct 6; ALUOp 2; ALUSrc 1; RegDst 1; MemRead 1; MemWrite 1; MemtoReg 1; RegWrite 1.
REQ-003 Further inputs SHALL be: flush 1 (drop the held instruction); out_ready 1 (execute stage accepts).
REQ-004 Outputs SHALL be: in_ready 1; out_valid 1; ALU_A 32; ALU_B 32; ALU_Control 4; Store_data 32; Write_reg 5; MemRead_q, MemWrite_q, MemtoReg_q, RegWrite_q 1 each; Illegal_op 1.
REQ-005 With FORWARD_EN defined, the block SHALL add these inputs: Exmem_RegWrite 1, Exmem_rd 5, Exmem_data 32, Memwb_RegWrite 1, Memwb_rd 5, Memwb_data 32.

Function
REQ-006 The block SHALL be a single-entry pipeline register, with in_ready = !out_valid || out_ready (combinational).
REQ-007 The block SHALL capture on the clk edge when in_valid && in_ready && !flush, then set out_valid=1 one cycle later (latency 1).
REQ-008 When out_valid && out_ready and no new capture occurs, the block SHALL clear out_valid; when out_valid && !out_ready, all outputs SHALL hold stable.
REQ-009 Flush SHALL have priority: the block SHALL clear out_valid, MemRead_q, MemWrite_q, RegWrite_q, and Illegal_op next cycle, and SHALL discard any same-cycle input handshake.
REQ-010 ALU_Control SHALL be decoded at capture: ALUOp 00->0010 (add), 01->0110 (sub), 11->0001 (or).
REQ-011 For ALUOp 10, decode SHALL use funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
REQ-012 An unlisted funct with ALUOp 10 SHALL yield ALU_Control=1111, Illegal_op=1, and RegWrite_q=MemWrite_q=MemRead_q=0.
REQ-013 The A operand SHALL be the rs operand, and ALU_B SHALL be Sign_ext_imm when ALUSrc=1, else the rt operand; Store_data SHALL always be the rt operand.
REQ-014 Write_reg SHALL be Rd when RegDst=1, else Rt; if the selected Write_reg is 0, RegWrite_q SHALL be forced to 0.
REQ-015 Operand selection, forwarding and decode SHALL be evaluated on the capture-cycle inputs only; stalls SHALL NOT re-sample them.

Reset
REQ-016 When rst_n=0 at a clk edge, the block SHALL clear out_valid, MemRead_q, MemWrite_q, MemtoReg_q, RegWrite_q, and Illegal_op to 0, and SHALL clear ALU_A, ALU_B, Store_data, and Write_reg to 0.
REQ-017 During reset ALU_Control SHALL be 0010 and in_ready SHALL be 1 (out_valid=0); reset SHALL override flush and capture.
REQ-018 Reset mid-stall SHALL discard the held instruction with no output pulse.

Configuration
REQ-019 With FORWARD_EN defined, the block SHALL select the rs operand as: Exmem_data if Exmem_RegWrite && Exmem_rd!=0 && Exmem_rd==Rs; else Memwb_data if Memwb_RegWrite && Memwb_rd!=0 && Memwb_rd==Rs; else Read_data1.
REQ-020 With FORWARD_EN defined, the rt operand SHALL be selected the same way against Rt and Read_data2; EX/MEM SHALL win when both match.
REQ-021 Without FORWARD_EN, the forwarding ports SHALL be absent and the block SHALL use Read_data1 and Read_data2 directly as the rs and rt operands.

Structure
REQ-022 Shared package mips_pkg SHALL hold the ALU_Control codes (AND, OR, ADD, SUB, SLT, NOR, ILLEGAL=1111), the ALUOp encodings, and the R-type funct constants, so that the ALU and this block share one definition.
REQ-023 The combinational ALUOp/funct decode SHALL be a sub-module named alu_ctrl_dec; forwarding muxes and pipeline registers SHALL stay in id_ex_stage.

Verification
REQ-024 Scenario: R-type add with ALUOp=10, funct=100000, Read_data1=5, Read_data2=7, RegDst=1, Rd=3, in_valid=1, out_ready=1 -> next cycle out_valid=1, ALU_A=5, ALU_B=7, ALU_Control=0010, Write_reg=3, RegWrite_q=1.
REQ-025 Scenario: lw with ALUOp=00, ALUSrc=1, Sign_ext_imm=0xFFFFFFFC, RegDst=0, Rt=8 -> ALU_B=0xFFFFFFFC, ALU_Control=0010, Write_reg=8, MemRead_q=1.
REQ-026 Scenario: out_ready=0 for 3 cycles with a new in_valid presented -> in_ready=0, outputs unchanged; when out_ready=1 the second instruction is captured and appears 1 cycle later, and no instruction is lost or duplicated.
REQ-027 Scenario: flush=1 with in_valid=1 and a held store -> next cycle out_valid=0, MemWrite_q=0, and the incoming instruction never appears.
REQ-028 Scenario: funct=000111 with ALUOp=10 -> ALU_Control=1111, Illegal_op=1, RegWrite_q=0; and RegDst=1 with Rd=0 on a valid add -> RegWrite_q=0.
REQ-029 Scenario (FORWARD_EN): Rs=4 with Exmem_rd=4 (data 0x11) and Memwb_rd=4 (data 0x22), both RegWrite=1 -> ALU_A=0x11; with Exmem_rd=0 -> ALU_A=0x22.
